// File: rtl/framebuf_uart_dump.sv
// Streams a stored frame from a single-clock RAM read port over a built-in 8N1 UART.
// Define FRAMEBUF_UART_DUMP_CSUM_EN to append a mod-256 checksum byte after the pixel data.
module framebuf_uart_dump #(
  parameter int         CLK_HZ      = 25000000,
  parameter int         BAUD        = 115200,
  parameter int         WORD_BYTES  = 4,
  parameter int         ADDR_W      = 17,
  parameter int         FRAME_BYTES = 307200,
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         SYNC_LEN    = 2
) (
  input  logic                    pixclk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    abort,
  output logic [ADDR_W-1:0]       ram_addr,
  input  logic [8*WORD_BYTES-1:0] ram_data,
  output logic                    tx,
  output logic                    busy,
  output logic                    done,
  output logic [ADDR_W+2:0]       byte_idx
);
  localparam int DIV    = CLK_HZ / BAUD;
  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = ADDR_W + 3;
  localparam int BAUD_W = $clog2(DIV);

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_FETCH, S_WAIT, S_LOAD, S_SEND, S_NEXT, S_DONE
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
    , S_CSUM
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [9:0]          shift_q, shift_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [3:0]          bit_q, bit_d;
  logic [3:0]          sync_q, sync_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                abort_q, abort_d;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic [IDX_W-1:0]  lane, next_idx, next_lane;
  logic [WORD_W-1:0] cur_word;
  logic [7:0]        cur_byte, load_val;
  logic              sending, byte_end, abort_now, load_byte;

  assign lane      = idx_q % IDX_W'(WORD_BYTES);
  assign next_idx  = idx_q + 1'b1;
  assign next_lane = next_idx % IDX_W'(WORD_BYTES);
  assign abort_now = abort_q | abort;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
  assign sending   = (state_q == S_SYNC) || (state_q == S_SEND) || (state_q == S_CSUM);
`else
  assign sending   = (state_q == S_SYNC) || (state_q == S_SEND);
`endif
  assign byte_end  = sending && (bit_q == 4'd9) && (baud_q == '0);

  always_ff @(posedge pixclk) begin
    if (reset) begin
      state_q <= S_IDLE;
      shift_q <= '1;
      baud_q  <= '0;
      bit_q   <= '0;
      sync_q  <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      word_q  <= '0;
      abort_q <= 1'b0;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sync_q  <= sync_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
      abort_q <= abort_d;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    baud_d    = baud_q;
    bit_d     = bit_q;
    sync_d    = sync_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    word_d    = word_q;
    abort_d   = (state_q == S_IDLE) ? 1'b0 : abort_now;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
    csum_d    = csum_q;
`endif
    load_byte = 1'b0;
    load_val  = SYNC_BYTE;
    // Lane 0 is only ever reached via FETCH/WAIT, so fresh RAM data is on the bus.
    cur_word  = (lane == '0) ? ram_data : word_q;
    cur_byte  = cur_word[7:0];
    for (int k = 0; k < WORD_BYTES; k++)
      if (lane == IDX_W'(k)) cur_byte = cur_word[8*k +: 8];

    // Shift in ones so the line rests high once the stop bit has gone out.
    if (sending) begin
      if (baud_q == '0) begin
        shift_d = {1'b1, shift_q[9:1]};
        baud_d  = BAUD_W'(DIV - 1);
        bit_d   = bit_q + 4'd1;
      end else begin
        baud_d  = baud_q - 1'b1;
      end
    end

    case (state_q)
      S_IDLE: if (start) begin
        idx_d  = '0;
        addr_d = '0;
        sync_d = '0;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
        csum_d = '0;
`endif
        if (SYNC_LEN > 0) begin
          state_d   = S_SYNC;
          load_byte = 1'b1;
        end else begin
          state_d   = S_FETCH;
        end
      end
      S_SYNC: if (byte_end) begin
        if (abort_now)                         state_d = S_IDLE;
        else if (sync_q == 4'(SYNC_LEN - 1))   state_d = S_FETCH;
        else begin
          sync_d    = sync_q + 4'd1;
          load_byte = 1'b1;
        end
      end
      S_FETCH: begin
        addr_d  = ADDR_W'(idx_q / IDX_W'(WORD_BYTES));
        state_d = abort_now ? S_IDLE : S_WAIT;
      end
      S_WAIT: state_d = abort_now ? S_IDLE : S_LOAD;
      S_LOAD: begin
        if (abort_now) state_d = S_IDLE;
        else begin
          word_d    = cur_word;
          load_byte = 1'b1;
          load_val  = cur_byte;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
          csum_d    = csum_q + cur_byte;
`endif
          state_d   = S_SEND;
        end
      end
      S_SEND: if (byte_end) state_d = abort_now ? S_IDLE : S_NEXT;
      S_NEXT: begin
        if (abort_now) state_d = S_IDLE;
        else if (idx_q == IDX_W'(FRAME_BYTES - 1)) begin
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
          load_byte = 1'b1;
          load_val  = csum_q;
          state_d   = S_CSUM;
`else
          state_d   = S_DONE;
`endif
        end else begin
          idx_d   = next_idx;
          state_d = (next_lane == '0) ? S_FETCH : S_LOAD;
        end
      end
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
      S_CSUM: if (byte_end) state_d = abort_now ? S_IDLE : S_DONE;
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (load_byte) begin
      shift_d = {1'b1, load_val, 1'b0};
      baud_d  = BAUD_W'(DIV - 1);
      bit_d   = '0;
    end
  end

  assign tx       = shift_q[0];
  assign ram_addr = addr_q;
  assign byte_idx = idx_q;
  assign done     = (state_q == S_DONE);
  assign busy     = (state_q != S_IDLE) && (state_q != S_DONE);

endmodule

// File: tb/tb_framebuf_uart_dump.sv
// Self-checking bench for framebuf_uart_dump: two instances (full-word and partial-word frames)
// decoded cycle by cycle and compared against a byte-list model built from the RAM contents.
module tb_framebuf_uart_dump;
  localparam int         DIV  = 8;
  localparam int         WB   = 4;
  localparam int         SLEN = 2;
  localparam logic [7:0] SB   = 8'hA5;
`ifdef FRAMEBUF_UART_DUMP_CSUM_EN
  localparam bit CSUM_ON = 1'b1;
`else
  localparam bit CSUM_ON = 1'b0;
`endif

  logic        pixclk, reset, abort;
  logic        start_v [2];
  logic [3:0]  ram_addr_v [2];
  logic [31:0] ram_data_v [2];
  logic        tx_v [2], busy_v [2], done_v [2];
  logic [6:0]  idx_v [2];
  logic [31:0] mem [16];

  int          n_tests, n_fail, sel, done_cnt;
  logic [15:0] addr_mask;
  logic [7:0]  exp_q [$];

  framebuf_uart_dump #(.CLK_HZ(16), .BAUD(2), .WORD_BYTES(WB), .ADDR_W(4),
                       .FRAME_BYTES(8), .SYNC_BYTE(SB), .SYNC_LEN(SLEN)) u_dut8 (
    .pixclk(pixclk), .reset(reset), .start(start_v[0]), .abort(abort),
    .ram_addr(ram_addr_v[0]), .ram_data(ram_data_v[0]), .tx(tx_v[0]),
    .busy(busy_v[0]), .done(done_v[0]), .byte_idx(idx_v[0]));

  framebuf_uart_dump #(.CLK_HZ(16), .BAUD(2), .WORD_BYTES(WB), .ADDR_W(4),
                       .FRAME_BYTES(6), .SYNC_BYTE(SB), .SYNC_LEN(SLEN)) u_dut6 (
    .pixclk(pixclk), .reset(reset), .start(start_v[1]), .abort(abort),
    .ram_addr(ram_addr_v[1]), .ram_data(ram_data_v[1]), .tx(tx_v[1]),
    .busy(busy_v[1]), .done(done_v[1]), .byte_idx(idx_v[1]));

  initial pixclk = 1'b0;
  always #5 pixclk = ~pixclk;

  always @(posedge pixclk) begin
    ram_data_v[0] <= mem[ram_addr_v[0]];
    ram_data_v[1] <= mem[ram_addr_v[1]];
  end

  function automatic int frame_len(input int s);
    return (s == 0) ? 8 : 6;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge pixclk);
    if (done_v[sel] === 1'b1) done_cnt++;
    addr_mask[ram_addr_v[sel]] = 1'b1;
  endtask

  // Expected byte stream: preamble, then little-endian pixel bytes, then optional checksum.
  task automatic build_exp(input int npix, input bit csum);
    logic [7:0] s, b;
    s = 8'h00;
    exp_q.delete();
    for (int i = 0; i < SLEN; i++) exp_q.push_back(SB);
    for (int i = 0; i < npix; i++) begin
      b = 8'(mem[i / WB] >> (8 * (i % WB)));
      s = s + b;
      exp_q.push_back(b);
    end
    if (csum) exp_q.push_back(s);
  endtask

  // poke: 0 none, 1 abort pulse, 2 assert reset and abandon the byte, 3 start pulse
  task automatic recv_byte(input string tag, input logic [7:0] exp, input int pix,
                           input int max_gap, input int poke, input int poke_c);
    int gap, bad;
    logic [9:0] frame, bits;
    gap = 0; bad = 0; bits = '0;
    frame = {1'b1, exp, 1'b0};
    while (tx_v[sel] !== 1'b0 && gap < 300) begin
      tick();
      gap++;
    end
    check($sformatf("%s gap=%0d", tag, gap), 32'(gap <= max_gap), 32'd1);
    for (int c = 0; c < 10 * DIV; c++) begin
      if (tx_v[sel] !== frame[c / DIV]) bad++;
      if (c % DIV == DIV / 2) bits[c / DIV] = tx_v[sel];
      if (pix >= 0 && c == 40) check($sformatf("%s byte_idx", tag), 32'(idx_v[sel]), 32'(pix));
      if (c == poke_c) begin
        case (poke)
          1: abort = 1'b1;
          2: begin reset = 1'b1; return; end
          3: start_v[sel] = 1'b1;
          default: ;
        endcase
      end
      tick();
      if (c == poke_c) begin
        abort = 1'b0;
        start_v[sel] = 1'b0;
      end
    end
    check($sformatf("%s data", tag), 32'(bits[8:1]), 32'(exp));
    check($sformatf("%s timing", tag), 32'(bad), 32'd0);
  endtask

  // abort_k / start_k: index into the byte stream during which the pulse is raised (-1 none)
  task automatic full_dump(input string tag, input int abort_k, input int start_k);
    int fl, npix, pix, mg, poke, lows;
    logic [15:0] exp_mask;
    fl   = frame_len(sel);
    npix = (abort_k >= 0) ? abort_k - SLEN + 1 : fl;
    build_exp(npix, (abort_k < 0) && CSUM_ON);
    exp_mask = '0;
    for (int i = 0; i < npix; i++) exp_mask[i / WB] = 1'b1;
    done_cnt = 0; addr_mask = '0; lows = 0;
    start_v[sel] = 1'b1;
    tick();
    start_v[sel] = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      pix  = (k >= SLEN && k < SLEN + fl) ? k - SLEN : -1;
      mg   = (k == 0) ? 2 : (k < SLEN) ? 0 : 4;
      poke = (k == abort_k) ? 1 : (k == start_k) ? 3 : 0;
      recv_byte($sformatf("%s b%0d", tag, k), exp_q[k], pix, mg, poke, 35);
    end
    for (int c = 0; c < 30 * DIV; c++) begin
      if (tx_v[sel] !== 1'b1) lows++;
      tick();
    end
    check($sformatf("%s idle tx", tag), 32'(lows), 32'd0);
    check($sformatf("%s busy", tag), 32'(busy_v[sel]), 32'd0);
    check($sformatf("%s done count", tag), 32'(done_cnt), (abort_k < 0) ? 32'd1 : 32'd0);
    check($sformatf("%s ram_addr set", tag), 32'(addr_mask), 32'(exp_mask));
  endtask

  initial begin
    n_tests = 0; n_fail = 0; sel = 0; done_cnt = 0; addr_mask = '0;
    reset = 1'b1; abort = 1'b0; start_v[0] = 1'b0; start_v[1] = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    mem[0] = 32'h44332211;
    mem[1] = 32'h88776655;
    repeat (3) @(negedge pixclk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset tx%0d", d), 32'(tx_v[d]), 32'd1);
      check($sformatf("reset busy%0d", d), 32'(busy_v[d]), 32'd0);
      check($sformatf("reset done%0d", d), 32'(done_v[d]), 32'd0);
      check($sformatf("reset addr%0d", d), 32'(ram_addr_v[d]), 32'd0);
      check($sformatf("reset idx%0d", d), 32'(idx_v[d]), 32'd0);
    end
    reset = 1'b0;
    tick();

    sel = 0; full_dump("basic", -1, -1);
    sel = 1; full_dump("partial", -1, -1);
    sel = 0; full_dump("abort", SLEN + 2, -1);
    sel = 0; full_dump("start_busy", -1, SLEN);

    // Reset during data bit 4 of the second pixel byte.
    sel = 0;
    build_exp(8, 1'b0);
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int k = 0; k < SLEN + 1; k++)
      recv_byte($sformatf("pre_rst b%0d", k), exp_q[k], (k >= SLEN) ? k - SLEN : -1, 4, 0, -1);
    recv_byte("rst byte", exp_q[SLEN + 1], 1, 4, 2, 5 * DIV + 2);
    tick();
    check("rst tx", 32'(tx_v[0]), 32'd1);
    check("rst busy", 32'(busy_v[0]), 32'd0);
    check("rst addr", 32'(ram_addr_v[0]), 32'd0);
    check("rst idx", 32'(idx_v[0]), 32'd0);
    reset = 1'b0;
    tick();
    full_dump("after_rst", -1, -1);

    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < 2; i++) mem[i] = $urandom;
      sel = it % 2;
      if (it < 4) full_dump($sformatf("rand%0d", it), -1, -1);
      else full_dump($sformatf("rand_abort%0d", it),
                     SLEN + int'($urandom_range(0, frame_len(sel) - 1)), -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
